// File: rtl/ram_loader_pkg.sv
// Shared types and defaults for the program-RAM serial loader.
package ram_loader_pkg;
  localparam int RAM_DEPTH       = 16;
  localparam int DEF_ADDR_W      = 4;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
    ST_WRITE  = 3'd2,
    ST_READ   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_FINISH = 3'd5
  } state_e;
endpackage

// File: rtl/ram_loader_if.sv
// Write/readback port between the loader (master) and the program RAM (slave).
interface ram_loader_if
  import ram_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic [ADDR_W-1:0] RAM_ADDR;
  logic [DATA_W-1:0] RAM_DIN;
  logic              RAM_WE;
  logic [DATA_W-1:0] RAM_DOUT;

  modport master (output RAM_ADDR, output RAM_DIN, output RAM_WE, input RAM_DOUT);
  modport slave  (input RAM_ADDR, input RAM_DIN, input RAM_WE, output RAM_DOUT);
endinterface

// File: rtl/ram_loader_sync.sv
// STAGES-deep synchroniser for one asynchronous input, with rise/fall pulses.
module ram_loader_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] chain_q, chain_d;
  logic              prev_q, prev_d;

  always_comb begin
    chain_d = (chain_q << 1) | STAGES'(async_i);
    prev_d  = chain_q[STAGES-1];
  end

  // Clearing to 0 means a CSn held low across reset is not seen as a new fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
    end
  end

  assign sync_o = chain_q[STAGES-1];
  assign rise_o = sync_o & ~prev_q;
  assign fall_o = ~sync_o & prev_q;
endmodule

// File: rtl/ram_loader.sv
// Serial-to-RAM program loader; holds the CPU in HALT while it owns the RAM port.
// Readback verification is built only when LOADER_VERIFY_EN is defined.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          PROG_CSn,
  input  logic          PROG_SCK,
  input  logic          PROG_SDI,
  ram_loader_if.master  ram,
  output logic          HALT,
  output logic          LOADED,
  output logic          OVERFLOW,
  output logic          VERIFY_ERR
);
  localparam int BC_W = $clog2(DATA_W);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);
  localparam int I_SDI = 0, I_SCK = 1, I_CS = 2;

  logic [2:0] lvl, rise, fall;

  ram_loader_sync #(.STAGES(SYNC_STAGES)) u_sync [2:0] (
    .clk    (CLK),
    .rst    (RESET),
    .async_i({PROG_CSn, PROG_SCK, PROG_SDI}),
    .sync_o (lvl),
    .rise_o (rise),
    .fall_o (fall)
  );

  logic cs_fall, cs_rise, sck_rise, sdi;
  assign cs_fall  = fall[I_CS];
  assign cs_rise  = rise[I_CS];
  assign sck_rise = rise[I_SCK];
  assign sdi      = lvl[I_SDI];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, ram_addr_q, ram_addr_d;
  logic [BC_W-1:0]   bitcnt_q, bitcnt_d;
  logic [DATA_W-1:0] sr_q, sr_d, wbuf_q, wbuf_d, shifted;
  logic              ovf_q, ovf_d, fin_pend_q, fin_pend_d, byte_done;
`ifdef LOADER_VERIFY_EN
  logic              verr_q, verr_d;
  wire unused_ok = ^{lvl[I_CS], lvl[I_SCK], rise[I_SDI], fall[I_SCK], fall[I_SDI]};
`else
  wire unused_ok = ^{lvl[I_CS], lvl[I_SCK], rise[I_SDI], fall[I_SCK], fall[I_SDI], ram.RAM_DOUT};
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      ram_addr_q <= '0;
      bitcnt_q   <= '0;
      sr_q       <= '0;
      wbuf_q     <= '0;
      ovf_q      <= 1'b0;
      fin_pend_q <= 1'b0;
`ifdef LOADER_VERIFY_EN
      verr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      ram_addr_q <= ram_addr_d;
      bitcnt_q   <= bitcnt_d;
      sr_q       <= sr_d;
      wbuf_q     <= wbuf_d;
      ovf_q      <= ovf_d;
      fin_pend_q <= fin_pend_d;
`ifdef LOADER_VERIFY_EN
      verr_q     <= verr_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    ram_addr_d = ram_addr_q;
    bitcnt_d   = bitcnt_q;
    sr_d       = sr_q;
    wbuf_d     = wbuf_q;
    ovf_d      = ovf_q;
    fin_pend_d = fin_pend_q;
    byte_done  = 1'b0;
    shifted    = {sr_q[DATA_W-2:0], sdi};
`ifdef LOADER_VERIFY_EN
    verr_d     = verr_q;
`endif
    // Shifting is independent of the access states so no SCK edge is dropped.
    if (state_q != ST_IDLE && sck_rise) begin
      sr_d = shifted;
      if (bitcnt_q == LAST_BIT) begin
        bitcnt_d  = '0;
        wbuf_d    = shifted;
        byte_done = 1'b1;
      end else begin
        bitcnt_d  = bitcnt_q + 1'b1;
      end
    end
    case (state_q)
      ST_IDLE: if (cs_fall) begin
        state_d    = ST_SHIFT;
        addr_d     = '0;
        bitcnt_d   = '0;
        ovf_d      = 1'b0;
        fin_pend_d = 1'b0;
`ifdef LOADER_VERIFY_EN
        verr_d     = 1'b0;
`endif
      end
      ST_SHIFT: begin
        if (byte_done) begin
          state_d    = ST_WRITE;
          ram_addr_d = addr_q;
          fin_pend_d = cs_rise;
        end else if (cs_rise) begin
          state_d  = ST_FINISH;
          bitcnt_d = '0;
        end
      end
`ifdef LOADER_VERIFY_EN
      ST_WRITE: begin
        fin_pend_d = fin_pend_q | cs_rise;
        state_d    = ST_READ;
      end
      ST_READ: begin
        fin_pend_d = fin_pend_q | cs_rise;
        state_d    = ST_CHECK;
      end
      ST_CHECK: begin
        if (ram.RAM_DOUT != wbuf_q) verr_d = 1'b1;
        addr_d     = addr_q + 1'b1;
        if (&addr_q) ovf_d = 1'b1;
        fin_pend_d = 1'b0;
        state_d    = (fin_pend_q || cs_rise) ? ST_FINISH : ST_SHIFT;
      end
`else
      ST_WRITE: begin
        addr_d     = addr_q + 1'b1;
        if (&addr_q) ovf_d = 1'b1;
        fin_pend_d = 1'b0;
        state_d    = (fin_pend_q || cs_rise) ? ST_FINISH : ST_SHIFT;
      end
`endif
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    HALT         = (state_q != ST_IDLE);
    LOADED       = (state_q == ST_FINISH);
    OVERFLOW     = ovf_q;
    ram.RAM_WE   = (state_q == ST_WRITE);
    ram.RAM_ADDR = ram_addr_q;
    ram.RAM_DIN  = wbuf_q;
`ifdef LOADER_VERIFY_EN
    VERIFY_ERR   = verr_q;
`else
    VERIFY_ERR   = 1'b0;
`endif
  end
endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: scoreboard of expected RAM writes plus status checks.
module tb_ram_loader;
  logic CLK = 1'b0, RESET = 1'b1;
  logic PROG_CSn = 1'b1, PROG_SCK = 1'b0, PROG_SDI = 1'b0;
  logic HALT, LOADED, OVERFLOW, VERIFY_ERR;

  ram_loader_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  ram_loader #(.ADDR_W(4), .DATA_W(8), .SYNC_STAGES(2)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .PROG_CSn  (PROG_CSn),
    .PROG_SCK  (PROG_SCK),
    .PROG_SDI  (PROG_SDI),
    .ram       (bus),
    .HALT      (HALT),
    .LOADED    (LOADED),
    .OVERFLOW  (OVERFLOW),
    .VERIFY_ERR(VERIFY_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        sb[$];
  logic [7:0] mem[16];
  logic [7:0] stuck_mask = 8'hFF;
  logic [3:0] exp_addr = 4'd0;
  int total = 0, bad = 0, loaded_cnt = 0;

  initial for (int i = 0; i < 16; i++) mem[i] = 8'h00;

  // RAM model: registered read, optional stuck-at-0 bits on write
  always @(posedge CLK) begin
    if (bus.RAM_WE === 1'b1) mem[bus.RAM_ADDR] <= bus.RAM_DIN & stuck_mask;
    bus.RAM_DOUT <= mem[bus.RAM_ADDR];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (LOADED === 1'b1) loaded_cnt++;
    if (bus.RAM_WE === 1'b1) begin
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL wr_unexpected: observed addr=%0h data=%0h expected no write",
               bus.RAM_ADDR, bus.RAM_DIN);
      end
      if (sb.size() != 0) begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", 32'(bus.RAM_ADDR), 32'(e.addr));
        chk("wr_data", 32'(bus.RAM_DIN), 32'(e.data));
      end
    end
  end

  task automatic clk_n(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_bit(input logic b);
    PROG_SDI = b;
    clk_n(4);
    PROG_SCK = 1'b1;
    clk_n(4);
    PROG_SCK = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    sb.push_back('{addr: exp_addr, data: b});
    exp_addr++;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic start_session();
    PROG_CSn = 1'b0;
    exp_addr = 4'd0;
    clk_n(4);
  endtask

  task automatic wait_loaded(input string tag);
    int  base;
    bit  got;
    base = loaded_cnt;
    got  = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge CLK);
      if (LOADED === 1'b1) got = 1'b1;
    end
    chk({tag, "_loaded_seen"}, 32'(got), 32'd1);
    @(negedge CLK);
    chk({tag, "_halt_after"}, 32'(HALT), 32'd0);
    clk_n(3);
    chk({tag, "_loaded_once"}, 32'(loaded_cnt - base), 32'd1);
    chk({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic end_session(input string tag);
    PROG_CSn = 1'b1;
    wait_loaded(tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    RESET = 1'b1;
    clk_n(3);
    RESET = 1'b0;
    @(negedge CLK);
    chk("rst_halt",   32'(HALT),         32'd0);
    chk("rst_we",     32'(bus.RAM_WE),   32'd0);
    chk("rst_loaded", 32'(LOADED),       32'd0);
    chk("rst_ovf",    32'(OVERFLOW),     32'd0);
    chk("rst_verr",   32'(VERIFY_ERR),   32'd0);
    chk("rst_addr",   32'(bus.RAM_ADDR), 32'd0);
    chk("rst_din",    32'(bus.RAM_DIN),  32'd0);

    // three-byte load
    start_session();
    chk("t2_halt", 32'(HALT), 32'd1);
    send_byte(8'hA5);
    send_byte(8'h3C);
    send_byte(8'hFF);
    end_session("t2");
    chk("t2_mem1", 32'(mem[1]), 32'h3C);

    // 12 bits: trailing partial byte dropped
    start_session();
    send_byte(8'h5A);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    end_session("t3");
    chk("t3_mem0", 32'(mem[0]), 32'h5A);

    // 17 bytes: address wraps, overflow sticky
    start_session();
    for (int i = 0; i < 17; i++) send_byte(8'(i));
    chk("t4_ovf", 32'(OVERFLOW), 32'd1);
    chk("t4_mem15", 32'(mem[15]), 32'h0F);
    chk("t4_mem0", 32'(mem[0]), 32'h10);
    end_session("t4");
    chk("t4_ovf_sticky", 32'(OVERFLOW), 32'd1);

    // CSn rise lands in the WRITE cycle of the 8th bit
    start_session();
    chk("t5_ovf_clr", 32'(OVERFLOW), 32'd0);
    chk("t5_halt", 32'(HALT), 32'd1);
    sb.push_back('{addr: 4'd0, data: 8'hC3});
    for (int i = 7; i >= 1; i--) send_bit(1'((8'hC3 >> i) & 8'h01));
    PROG_SDI = 1'b1;
    clk_n(4);
    PROG_SCK = 1'b1;
    clk_n(1);
    PROG_CSn = 1'b1;
    wait_loaded("t5");
    PROG_SCK = 1'b0;
    chk("t5_mem0", 32'(mem[0]), 32'hC3);

    // reset in the middle of a session with overflow set
    start_session();
    for (int i = 0; i < 17; i++) send_byte(8'hE0 + 8'(i));
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    chk("t1_halt_pre", 32'(HALT), 32'd1);
    chk("t1_ovf_pre", 32'(OVERFLOW), 32'd1);
    base = loaded_cnt;
    RESET = 1'b1;
    clk_n(2);
    RESET = 1'b0;
    @(negedge CLK);
    chk("t1_halt",   32'(HALT),       32'd0);
    chk("t1_we",     32'(bus.RAM_WE), 32'd0);
    chk("t1_loaded", 32'(LOADED),     32'd0);
    chk("t1_ovf",    32'(OVERFLOW),   32'd0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    chk("t1_halt_idle", 32'(HALT), 32'd0);
    PROG_CSn = 1'b1;
    clk_n(10);
    chk("t1_no_loaded", 32'(loaded_cnt - base), 32'd0);
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);

`ifdef LOADER_VERIFY_EN
    // readback against a RAM with bit 0 stuck low
    stuck_mask = 8'hFE;
    start_session();
    chk("t6_verr_start", 32'(VERIFY_ERR), 32'd0);
    send_byte(8'h01);
    chk("t6_verr_set", 32'(VERIFY_ERR), 32'd1);
    end_session("t6a");
    chk("t6_verr_sticky", 32'(VERIFY_ERR), 32'd1);
    start_session();
    chk("t6_verr_clr", 32'(VERIFY_ERR), 32'd0);
    send_byte(8'h02);
    chk("t6_verr_ok", 32'(VERIFY_ERR), 32'd0);
    end_session("t6b");
    stuck_mask = 8'hFF;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
